// File: rtl/sift_out_pkg.sv
// Shared types and helpers for the sift-out fault manager.
// Holds the FSM state encoding, the module count and the strike-counter width helper.
package sift_out_pkg;

    localparam int N_MOD = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OBSERVE = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_RECHECK = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    function automatic int strike_w(input int strike_max);
        return $clog2(strike_max + 1);
    endfunction

    function automatic logic two_or_more(input logic [N_MOD-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < N_MOD; i++) begin
            n += int'(v[i]);
        end
        return (n >= 2);
    endfunction

endpackage

// File: rtl/sift_out_strike_cnt.sv
// Per-module saturating strike counter with synchronous clear.
// tc_hit flags the increment that brings the count up to STRIKE_MAX.
module sift_out_strike_cnt #(
    parameter int STRIKE_MAX = 3,
    parameter int SW         = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc_hit
);

    logic [SW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != SW'(STRIKE_MAX))) begin
            cnt_d = cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_hit = inc && !clr && (cnt_q == SW'(STRIKE_MAX - 1));

endmodule

// File: rtl/sift_out_fault_manager.sv
// Sift-out fault manager: observes detector flags, issues one clear pulse per event,
// rechecks the flagged modules and permanently excludes repeat offenders.
module sift_out_fault_manager
    import sift_out_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int STRIKE_MAX  = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_MOD-1:0] flag,
    output logic             K,
    output logic [N_MOD-1:0] excl,
    output logic             degraded,
    output logic             failed,
    output logic [CNT_W-1:0] event_cnt,
    output logic             busy
);

    localparam int TMR_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW    = strike_w(STRIKE_MAX);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [N_MOD-1:0] mask_q, mask_d, refail_q, refail_d, pending_q, pending_d;
    logic [N_MOD-1:0] excl_q, excl_d;
    logic             k_q, k_d, degraded_q, degraded_d, failed_q, failed_d, busy_q, busy_d;
    logic [CNT_W-1:0] event_q, event_d;

    logic [N_MOD-1:0] live, refail_now, pend_now, seed;
    logic [N_MOD-1:0] strike_inc, strike_clr, strike_hit, excl_upd;
    logic             rc_end;

    assign live       = flag & ~excl_q;
    assign refail_now = refail_q | (live & mask_q);
    assign pend_now   = pending_q | (live & ~mask_q);
    assign seed       = live | pending_q;
    assign rc_end     = (state_q == ST_RECHECK) && (timer_q == '0);
    assign strike_inc = rc_end ? (mask_q & refail_now) : '0;
    assign strike_clr = rc_end ? (mask_q & ~refail_now) : '0;
    assign excl_upd   = excl_q | strike_hit;

    for (genvar i = 0; i < N_MOD; i++) begin : g_strike
        sift_out_strike_cnt #(
            .STRIKE_MAX(STRIKE_MAX),
            .SW        (SW)
        ) u_strike (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (strike_clr[i]),
            .inc   (strike_inc[i]),
            .tc_hit(strike_hit[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mask_d    = mask_q;
        refail_d  = refail_q;
        pending_d = pending_q;
        excl_d    = excl_q;
        unique case (state_q)
            ST_IDLE: begin
                if (seed != '0) begin
                    mask_d    = seed;
                    pending_d = '0;
                    timer_d   = TMR_LOAD;
                    state_d   = ST_OBSERVE;
                end
            end
            ST_OBSERVE: begin
                mask_d = mask_q | live;
                if (timer_q == '0) begin
                    state_d = ST_CLEAR;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_CLEAR: begin
                timer_d  = TMR_LOAD;
                refail_d = '0;
                state_d  = ST_RECHECK;
            end
            ST_RECHECK: begin
                refail_d  = refail_now;
                pending_d = pend_now;
                if (timer_q != '0) begin
                    timer_d = timer_q - TMR_W'(1);
                end else begin
                    // Window closed: commit exclusions, then retry, settle or lock.
                    excl_d = excl_upd;
                    if (two_or_more(excl_upd)) begin
                        state_d = ST_LOCKED;
                    end else if ((refail_now & ~excl_upd) != '0) begin
                        mask_d    = (refail_now | pend_now) & ~excl_upd;
                        pending_d = '0;
                        timer_d   = TMR_LOAD;
                        state_d   = ST_OBSERVE;
                    end else begin
                        mask_d    = '0;
                        pending_d = pend_now & ~excl_upd;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        k_d        = (state_d == ST_CLEAR);
        event_d    = (k_d && (event_q != '1)) ? event_q + CNT_W'(1) : event_q;
        degraded_d = |excl_d;
        failed_d   = two_or_more(excl_d);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            mask_q     <= '0;
            refail_q   <= '0;
            pending_q  <= '0;
            excl_q     <= '0;
            k_q        <= 1'b0;
            event_q    <= '0;
            degraded_q <= 1'b0;
            failed_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            mask_q     <= mask_d;
            refail_q   <= refail_d;
            pending_q  <= pending_d;
            excl_q     <= excl_d;
            k_q        <= k_d;
            event_q    <= event_d;
            degraded_q <= degraded_d;
            failed_q   <= failed_d;
            busy_q     <= busy_d;
        end
    end

    assign K         = k_q;
    assign excl      = excl_q;
    assign degraded  = degraded_q;
    assign failed    = failed_q;
    assign event_cnt = event_q;
    assign busy      = busy_q;

endmodule
